// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                             |
// | Description : Parametrised VGA raster controller. Generates h/v counters,|
// |               pixel-RAM addresses and read strobe, polarity-configurable |
// |               sync, data-enable, line/frame start pulses, a completed-   |
// |               frame counter and RGB gated to the active area. hs/vs/de   |
// |               and RGB leave together, two clocks after the counters.     |
// |               Optional macro VGA_TEST_PATTERN_EN replaces d_in with      |
// |               eight internal vertical colour bars.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int ROW_W    = 9,
  parameter int COL_W    = 10,
  parameter int FCNT_W   = 16
) (
  input  logic                   vga_clk,
  input  logic                   clrn,
  input  logic                   blank,
  input  logic [3*COLOR_W-1:0]   d_in,
  output logic [ROW_W-1:0]       row_addr,
  output logic [COL_W-1:0]       col_addr,
  output logic                   rdn,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic                   hs,
  output logic                   vs,
  output logic                   de,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [FCNT_W-1:0]      frame_cnt
);

  localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);

  localparam logic [c_hw-1:0] c_h_last  = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0] c_ha0     = c_hw'(H_SYNC + H_BP);
  localparam logic [c_hw-1:0] c_ha1     = c_hw'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [c_hw-1:0] c_hsync   = c_hw'(H_SYNC);
  localparam logic [c_vw-1:0] c_v_last  = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0] c_va0     = c_vw'(V_SYNC + V_BP);
  localparam logic [c_vw-1:0] c_va1     = c_vw'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [c_vw-1:0] c_vsync   = c_vw'(V_SYNC);

  // Reject timings the counters and address ports cannot represent.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_ACTIVE > (1 << COL_W) || V_ACTIVE > (1 << ROW_W)) begin : g_param_check
    $error("vga_timing_gen: illegal timing or address-width parameters");
  end

  // Counters and stage-1 state
  logic [c_hw-1:0]   h_q, h_d;
  logic [c_vw-1:0]   v_q, v_d;
  logic              rdn_q, rdn_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              hsa_q, hsa_d;
  logic              vsa_q, vsa_d;
  logic              ls_q, ls_d;
  logic              fs_q, fs_d;
  logic              seen_q, seen_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // Stage-2 state
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 de_q, de_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic                 w_show;
  logic [3*COLOR_W-1:0] w_pix;

  // Raster counters and stage-1 decode of the current (h,v) position.
  always_comb begin
    h_d    = h_q + c_hw'(1);
    v_d    = v_q;
    if (h_q == c_h_last) begin
      h_d = '0;
      v_d = (v_q == c_v_last) ? '0 : v_q + c_vw'(1);
    end
    rdn_d  = ~((h_q >= c_ha0) && (h_q < c_ha1) && (v_q >= c_va0) && (v_q < c_va1));
    // Plain modulo subtraction keeps off-screen addresses deterministic.
    col_d  = COL_W'(32'(h_q) - 32'(H_SYNC + H_BP));
    row_d  = ROW_W'(32'(v_q) - 32'(V_SYNC + V_BP));
    hsa_d  = (h_q < c_hsync);
    vsa_d  = (v_q < c_vsync);
    ls_d   = (h_q == '0);
    fs_d   = (h_q == '0) && (v_q == '0);
    seen_d = seen_q;
    fcnt_d = fcnt_q;
    // The first frame after reset is not a completed frame, so it is skipped.
    if (fs_d) begin
      seen_d = 1'b1;
      if (seen_q) fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  // Register the counters and stage-1 outputs.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      h_q    <= '0;
      v_q    <= '0;
      rdn_q  <= 1'b1;
      col_q  <= '0;
      row_q  <= '0;
      hsa_q  <= 1'b0;
      vsa_q  <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      seen_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      rdn_q  <= rdn_d;
      col_q  <= col_d;
      row_q  <= row_d;
      hsa_q  <= hsa_d;
      vsa_q  <= vsa_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      seen_q <= seen_d;
      fcnt_q <= fcnt_d;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] w_bar;

  // Eight equal-width bars across the active columns; bar index bits pick r/g/b.
  always_comb begin
    w_bar = 3'((32'(col_q) * 32'd8) / 32'(H_ACTIVE));
    w_pix = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
  end
`else
  // RAM data arrives one clock after rdn, lining up with stage-1 state.
  always_comb begin
    w_pix = d_in;
  end
`endif

  // Stage-2 gating of colour and alignment of sync/enable with the pixel.
  always_comb begin
    w_show = ~rdn_q & ~blank;
    rgb_d  = w_show ? w_pix : '0;
    de_d   = w_show;
    hs_d   = hsa_q ^ ~HS_POL;
    vs_d   = vsa_q ^ ~VS_POL;
  end

  // Register the stage-2 outputs.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else begin
      rgb_q <= rgb_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign row_addr    = row_q;
  assign col_addr    = col_q;
  assign rdn         = rdn_q;
  assign {b, g, r}   = rgb_q;
  assign de          = de_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                          |
// | Description : Directed self-checking bench for vga_timing_gen using a    |
// |               reduced 25x11 raster (16x6 active). Instance A uses        |
// |               active-low sync, instance B active-high sync.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

  // Reduced raster: line = 4 sync + 3 bp + 16 active + 2 fp = 25 clocks,
  // frame = 2 sync + 2 bp + 6 active + 1 fp = 11 lines = 275 clocks.
  localparam int HT   = 25;
  localparam int VT   = 11;
  localparam int FT   = 275;
  localparam int HA0  = 7;
  localparam int VA0  = 4;
  localparam int HACT = 16;
  localparam int VACT = 6;
  localparam int HSY  = 4;
  localparam int VSY  = 2;
  localparam int BL_V = 5;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        blank = 1'b0;
  logic [11:0] d_in = 12'hABC;

  logic [2:0]  row_a, row_b;
  logic [3:0]  col_a, col_b;
  logic        rdn_a, rdn_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, de_a, fs_a, ls_a;
  logic        hs_b, vs_b, de_b, fs_b, ls_b;
  logic [15:0] fcnt_a, fcnt_b;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  bit bl_edge = 1'b0;
  bit blank_en = 1'b0;

  int first_rdn_k, first_hs_k, rdn_low_f0, hs_low_f0, vs_run, vs_run_max;
  int fs_count, act_lines;
  bit prev_rdn;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .COLOR_W(4), .ROW_W(3), .COL_W(4), .FCNT_W(16)
  ) u_dut_a (
    .vga_clk(clk), .clrn(clrn), .blank(blank), .d_in(d_in),
    .row_addr(row_a), .col_addr(col_a), .rdn(rdn_a),
    .r(r_a), .g(g_a), .b(b_a), .hs(hs_a), .vs(vs_a), .de(de_a),
    .frame_start(fs_a), .line_start(ls_a), .frame_cnt(fcnt_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .COLOR_W(4), .ROW_W(3), .COL_W(4), .FCNT_W(16)
  ) u_dut_b (
    .vga_clk(clk), .clrn(clrn), .blank(blank), .d_in(d_in),
    .row_addr(row_b), .col_addr(col_b), .rdn(rdn_b),
    .r(r_b), .g(g_b), .b(b_b), .hs(hs_b), .vs(vs_b), .de(de_b),
    .frame_start(fs_b), .line_start(ls_b), .frame_cnt(fcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic bit act_at(input int t);
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    return (h >= HA0) && (h < HA0 + HACT) && (v >= VA0) && (v < VA0 + VACT);
  endfunction

  task automatic check_reset(input string ph);
    chk({ph, "_rdn"},  rdn_a, 1);
    chk({ph, "_row"},  row_a, 0);
    chk({ph, "_col"},  col_a, 0);
    chk({ph, "_rgb"},  {b_a, g_a, r_a}, 0);
    chk({ph, "_de"},   de_a, 0);
    chk({ph, "_hs"},   hs_a, 1);
    chk({ph, "_vs"},   vs_a, 1);
    chk({ph, "_fs"},   fs_a, 0);
    chk({ph, "_ls"},   ls_a, 0);
    chk({ph, "_fcnt"}, fcnt_a, 0);
    chk({ph, "_hs_b"}, hs_b, 0);
    chk({ph, "_vs_b"}, vs_b, 0);
    chk({ph, "_rdn_b"}, rdn_b, 1);
  endtask

  task automatic check_outputs();
    int t1, h1, v1, t2, h2, v2;
    bit a2;
    logic [11:0] pix;
    logic [2:0] bar;
    if (k >= 1) begin
      t1 = k - 1;
      h1 = t1 % HT;
      v1 = (t1 / HT) % VT;
      chk("rdn", rdn_a, act_at(t1) ? 0 : 1);
      chk("col", col_a, (h1 + 16 - HA0) % 16);
      chk("row", row_a, (v1 + 8 - VA0) % 8);
      chk("line_start", ls_a, (h1 == 0));
      chk("frame_start", fs_a, (h1 == 0 && v1 == 0));
      chk("frame_cnt", fcnt_a, t1 / FT);
    end
    if (k >= 2) begin
      t2 = k - 2;
      h2 = t2 % HT;
      v2 = (t2 / HT) % VT;
      a2 = act_at(t2) && !bl_edge;
`ifdef VGA_TEST_PATTERN_EN
      bar = 3'(((h2 + 16 - HA0) % 16) / 2);
      pix = a2 ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : 12'h000;
`else
      bar = 3'd0;
      pix = a2 ? 12'hABC : 12'h000;
`endif
      chk("de", de_a, a2);
      chk("r", r_a, pix[3:0]);
      chk("g", g_a, pix[7:4]);
      chk("b", b_a, pix[11:8]);
      chk("hs", hs_a, (h2 < HSY) ? 0 : 1);
      chk("vs", vs_a, (v2 < VSY) ? 0 : 1);
      chk("hs_pol", hs_b, (h2 < HSY));
      chk("vs_pol", vs_b, (v2 < VSY));
    end else begin
      chk("de_early", de_a, 0);
      chk("rgb_early", {b_a, g_a, r_a}, 0);
      chk("hs_early", hs_a, 1);
      chk("vs_early", vs_a, 1);
      chk("hs_pol_early", hs_b, 0);
    end
  endtask

  task automatic clear_stats();
    first_rdn_k = -1; first_hs_k = -1; rdn_low_f0 = 0; hs_low_f0 = 0;
    vs_run = 0; vs_run_max = 0; fs_count = 0; act_lines = 0; prev_rdn = 1'b1;
  endtask

  task automatic do_cycle();
    int tn;
    // Stage 2 at the next edge sees counter state k-1; blank one active line of frame 1.
    tn = k - 1;
    blank = blank_en && (tn >= 0) && (((tn / HT) % VT) == BL_V) && ((tn / FT) == 1);
    @(posedge clk);
    k++;
    bl_edge = blank;
    @(negedge clk);
    check_outputs();
    if (!rdn_a && first_rdn_k < 0) first_rdn_k = k;
    if (!hs_a && first_hs_k < 0 && k >= 1) first_hs_k = k;
    if (k >= 1 && k <= FT) begin
      if (!rdn_a) rdn_low_f0++;
      if (prev_rdn && !rdn_a) act_lines++;
    end
    prev_rdn = rdn_a;
    if (k >= 2 && k <= FT + 1) begin
      if (!hs_a) hs_low_f0++;
      if (!vs_a) vs_run++; else vs_run = 0;
      if (vs_run > vs_run_max) vs_run_max = vs_run;
    end
    if (fs_a) begin
      fs_count++;
      if (fs_count == 3) chk("fcnt_after_3_starts", fcnt_a, 2);
    end
  endtask

  task automatic check_stats();
    chk("first_rdn_k", first_rdn_k, 108);
    chk("first_hs_k", first_hs_k, 2);
    chk("rdn_low_per_frame", rdn_low_f0, VACT * HACT);
    chk("active_lines", act_lines, VACT);
    chk("hs_low_per_frame", hs_low_f0, VT * HSY);
    chk("vs_low_run", vs_run_max, VSY * HT);
  endtask

  initial begin
    // Reset held across several edges: every output at its reset level.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");

    // Release and run a little over two frames with one blanked line in frame 1.
    clear_stats();
    blank_en = 1'b1;
    clrn = 1'b1;
    k = 0;
    repeat (2 * FT + 5) do_cycle();
    check_stats();
    chk("frame_starts_seen", fs_count, 3);

    // Move to counter state h=12, v=5 of frame 2 and pull reset mid-line.
    blank_en = 1'b0;
    while (k < 2 * FT + 5 * HT + 12) do_cycle();
    chk("pre_reset_rdn", rdn_a, 0);
    chk("pre_reset_de", de_a, 1);
    clrn = 1'b0;
    #1;
    check_reset("async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("held");

    // Timing restarts from h = v = 0 after release.
    clear_stats();
    clrn = 1'b1;
    k = 0;
    repeat (FT + 25) do_cycle();
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
